bg_model_arbiter: RTL

BG_MODEL_ARBITER -- requirements
Module: bg_model_arbiter

---
 rtl/bg_model_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bg_model_arbiter.sv
// Two-requester arbiter for the background-model memory with registered command and in-order read return.
// Optional macro BG_ARB_FIXED_PRIO_EN: fixed priority to requester 0 instead of round-robin.
module bg_model_arbiter #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0]   wdata,
    output logic [1:0]            gnt,
    output logic [1:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    logic              xfer;
    logic              sel;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_id_q, mem_id_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
    logic [RD_LAT-1:0] rd_id_q, rd_id_d;

`ifndef BG_ARB_FIXED_PRIO_EN
    logic last_winner_q, last_winner_d;
`endif

    always_comb begin
        gnt = '0;
        if (!rst) begin
`ifdef BG_ARB_FIXED_PRIO_EN
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
`else
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_winner_q ? 2'b01 : 2'b10;
                default: gnt = '0;
            endcase
`endif
        end
    end

    assign xfer = |(req & gnt);
    assign sel  = gnt[1];

    always_comb begin
        mem_en_d    = xfer;
        mem_we_d    = mem_we_q;
        mem_id_d    = mem_id_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (xfer) begin
            mem_we_d    = we[sel];
            mem_id_d    = sel;
            mem_addr_d  = addr[sel*ADDR_W +: ADDR_W];
            mem_wdata_d = wdata[sel*DATA_W +: DATA_W];
        end
`ifndef BG_ARB_FIXED_PRIO_EN
        last_winner_d = xfer ? sel : last_winner_q;
`endif
    end

    // Tracker fed from the issued command so the tail stage lines up with mem_en + RD_LAT.
    always_comb begin
        rd_vld_d    = '0;
        rd_id_d     = '0;
        rd_vld_d[0] = mem_en_q & ~mem_we_q;
        rd_id_d[0]  = mem_id_q;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            rd_vld_d[i] = rd_vld_q[i-1];
            rd_id_d[i]  = rd_id_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_id_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_vld_q    <= '0;
            rd_id_q     <= '0;
`ifndef BG_ARB_FIXED_PRIO_EN
            last_winner_q <= 1'b1;
`endif
        end else begin
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_id_q    <= mem_id_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_vld_q    <= rd_vld_d;
            rd_id_q     <= rd_id_d;
`ifndef BG_ARB_FIXED_PRIO_EN
            last_winner_q <= last_winner_d;
`endif
        end
    end

    // Outputs forced to their reset values for the whole reset cycle, not just after it.
    assign mem_en    = mem_en_q & ~rst;
    assign mem_we    = mem_we_q & ~rst;
    assign mem_addr  = rst ? '0 : mem_addr_q;
    assign mem_wdata = rst ? '0 : mem_wdata_q;
    assign rvalid    = (rst || !rd_vld_q[RD_LAT-1]) ? 2'b00 :
                       (rd_id_q[RD_LAT-1] ? 2'b10 : 2'b01);
    assign rdata     = mem_rdata;

endmodule
